// File: rtl/dm_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_pkg
//  Description : Shared size encodings, FSM states and request error check
//                for the data-memory access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Reserved size, misalignment, or an out-of-range address (flag from caller).
    function automatic logic req_error(input logic [1:0] size,
                                       input logic [1:0] addr_lo,
                                       input logic       out_of_range);
        logic e;
        e = out_of_range;
        case (size)
            SZ_BYTE: e = e;
            SZ_HALF: e = e | addr_lo[0];
            SZ_WORD: e = e | (addr_lo != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_merge
//  Description : Byte/half lane insert for stores and lane extract with
//                sign/zero extension for loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_lane_merge
    import dm_access_pkg::*;
#(
    parameter int LITTLE_END = 1
) (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        ld_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [4:0]  w_sh;
    logic [31:0] w_mask;
    logic [31:0] w_shifted;

    generate
        if (LITTLE_END != 0) begin : g_little
            assign w_byte_sh = {lane, 3'b000};
            assign w_half_sh = {lane[1], 4'b0000};
        end else begin : g_big
            assign w_byte_sh = {~lane, 3'b000};
            assign w_half_sh = {~lane[1], 4'b0000};
        end
    endgenerate

    always_comb begin
        w_sh      = (size == SZ_HALF) ? w_half_sh : w_byte_sh;
        w_mask    = ((size == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
        w_shifted = old_word >> w_sh;
        merged    = (old_word & ~w_mask) | ((wdata << w_sh) & w_mask);
        load_data = old_word;
        case (size)
            SZ_BYTE: load_data = {{24{~ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: load_data = {{16{~ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: begin
                merged    = wdata;
                load_data = old_word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_unit
//  Description : Byte/half/word load-store sequencer in front of a word-wide
//                data memory; sub-word stores are read-modify-write.
//                Define DM_RANGE_CHECK_EN to flag addresses above DM_AW bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int DM_AW      = 10,
    parameter int LITTLE_END = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             wr,
    input  logic [1:0]       size,
    input  logic             ld_unsigned,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    input  logic [31:0]      dm_dout
);

    state_t            r_state;
    state_t            w_next;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [DM_AW-1:0]  r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              w_oor;
    logic              w_req_err;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;

`ifdef DM_RANGE_CHECK_EN
    assign w_oor = |addr[31:DM_AW];
`else
    // Upper address bits are ignored; the access wraps within the memory.
    logic w_unused_hi;
    assign w_oor       = 1'b0;
    assign w_unused_hi = ^addr[31:DM_AW];
`endif

    assign w_req_err = req_error(size, addr[1:0], w_oor);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_req_err)           w_next = DONE;
                    else if (!wr)            w_next = RD;
                    else if (size == SZ_WORD) w_next = WR;
                    else                     w_next = RD;
                end
            end
            RD:      w_next = r_wr ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req) begin
                r_wr    <= wr;
                r_size  <= size;
                r_uns   <= ld_unsigned;
                r_addr  <= addr[DM_AW-1:0];
                r_wdata <= wdata;
                r_err   <= w_req_err;
            end
            if (r_state == RD) begin
                r_word <= dm_dout;
                if (!r_wr) r_rdata <= w_load;
            end
        end
    end

    // During RD the lane logic sees live memory data so loads can be captured directly.
    assign w_old = (r_state == RD) ? dm_dout : r_word;

    dm_lane_merge #(
        .LITTLE_END (LITTLE_END)
    ) u_lane_merge (
        .old_word    (w_old),
        .wdata       (r_wdata),
        .size        (r_size),
        .lane        (r_addr[1:0]),
        .ld_unsigned (r_uns),
        .merged      (w_merged),
        .load_data   (w_load)
    );

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign err     = (r_state == DONE) & r_err;
    assign dm_we   = (r_state == WR);
    assign dm_din  = w_merged;
    assign dm_addr = {r_addr[DM_AW-1:2], 2'b00};
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_access_unit
//  Description : Directed self-checking bench for dm_access_unit with a
//                behavioural 1K data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [256];

    int          total = 0;
    int          bad   = 0;
    int          lat;
    int          wecnt;
    logic [31:0] din;
    logic [9:0]  da;
    logic        e;

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;

    dm_access_unit #(
        .DM_AW      (10),
        .LITTLE_END (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .wr          (wr),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_we       (dm_we),
        .dm_dout     (dm_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait (bounded) for done.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1; wr = w; size = sz; ld_unsigned = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; wr = ~w; size = 2'b11; ld_unsigned = ~u;
        addr = 32'hFFFF_FFFF; wdata = ~wd;
        lat = 1; wecnt = 0; din = '0; da = '0; e = 1'b0;
        while (!done && lat < 10) begin
            if (dm_we) begin
                wecnt++;
                din = dm_din;
                da  = dm_addr;
            end
            @(posedge clk); #1;
            lat++;
        end
        e = err;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00;
        ld_unsigned = 1'b0; addr = '0; wdata = '0;
        #12;
        check("rst_busy",    {31'd0, busy},  32'd0);
        check("rst_done",    {31'd0, done},  32'd0);
        check("rst_err",     {31'd0, err},   32'd0);
        check("rst_we",      {31'd0, dm_we}, 32'd0);
        check("rst_rdata",   rdata,          32'd0);
        check("rst_din",     dm_din,         32'd0);
        check("rst_addr",    {22'd0, dm_addr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store
        run_req(1'b1, 2'b10, 1'b0, 32'h000, 32'h0000_0BFA);
        check("sw_lat",   lat,   2);
        check("sw_we",    wecnt, 1);
        check("sw_din",   din,   32'h0000_0BFA);
        check("sw_addr",  {22'd0, da}, 32'd0);
        check("sw_err",   {31'd0, e},  32'd0);
        check("sw_mem",   mem[0], 32'h0000_0BFA);

        // Byte loads
        run_req(1'b0, 2'b00, 1'b0, 32'h001, 32'h0);
        check("lb1_data", rdata, 32'h0000_000B);
        check("lb1_lat",  lat,   2);
        check("lb1_we",   wecnt, 0);
        run_req(1'b0, 2'b00, 1'b0, 32'h000, 32'h0);
        check("lb0_data", rdata, 32'hFFFF_FFFA);
        run_req(1'b0, 2'b00, 1'b1, 32'h000, 32'h0);
        check("lbu0_data", rdata, 32'h0000_00FA);

        // Half store read-modify-write
        run_req(1'b1, 2'b10, 1'b0, 32'h004, 32'hAABB_CCDD);
        check("sw4_din",  din, 32'hAABB_CCDD);
        run_req(1'b1, 2'b01, 1'b0, 32'h006, 32'h0000_1234);
        check("sh_lat",   lat,   3);
        check("sh_we",    wecnt, 1);
        check("sh_din",   din,   32'h1234_CCDD);
        check("sh_addr",  {22'd0, da}, 32'h004);
        check("sh_mem",   mem[1], 32'h1234_CCDD);
        run_req(1'b0, 2'b01, 1'b1, 32'h006, 32'h0);
        check("lhu6_data", rdata, 32'h0000_1234);
        run_req(1'b0, 2'b01, 1'b0, 32'h004, 32'h0);
        check("lh4_data", rdata, 32'hFFFF_CCDD);

        // Error cases
        run_req(1'b0, 2'b10, 1'b0, 32'h002, 32'h0);
        check("mis_lat",  lat,   1);
        check("mis_err",  {31'd0, e}, 32'd1);
        check("mis_we",   wecnt, 0);
        check("mis_rdata", rdata, 32'hFFFF_CCDD);
        run_req(1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
        check("rsv_lat",  lat,   1);
        check("rsv_err",  {31'd0, e}, 32'd1);
        check("rsv_rdata", rdata, 32'hFFFF_CCDD);
        run_req(1'b1, 2'b01, 1'b0, 32'h003, 32'h0000_9999);
        check("msh_err",  {31'd0, e}, 32'd1);
        check("msh_we",   wecnt, 0);
        check("msh_mem",  mem[0], 32'h0000_0BFA);

        // Reset during the write cycle of a byte store
        req = 1'b1; wr = 1'b1; size = 2'b00; ld_unsigned = 1'b0;
        addr = 32'h000; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rw_we_pre", {31'd0, dm_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_we_rst",   {31'd0, dm_we}, 32'd0);
        check("rw_busy_rst", {31'd0, busy},  32'd0);
        check("rw_done_rst", {31'd0, done},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
        check("rw_reload", rdata, 32'h0000_0BFA);

        // Address beyond the memory
        run_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D);
`ifdef DM_RANGE_CHECK_EN
        check("oor_err", {31'd0, e}, 32'd1);
        check("oor_we",  wecnt, 0);
        check("oor_mem", mem[0], 32'h0000_0BFA);
`else
        check("wrap_err",  {31'd0, e}, 32'd0);
        check("wrap_addr", {22'd0, da}, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
        check("wrap_load", rdata, 32'hCAFE_F00D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
